// File: rtl/ofmaps_axis_out_fifo.sv
// Output-feature-map stream FIFO: producer beats (no backpressure) into an AXI4-Stream master
// with a registered first-word-fall-through output stage and frame tracking.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | between frames, no beat of the current frame accepted yet
// S_STREAM | inside a frame, at least one beat accepted, TLAST not yet seen
// S_DONE   | the TLAST beat was accepted on the previous edge (frame_done)
module ofmaps_axis_out_fifo #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH           = 16,
   parameter int ALMOST_FULL_MARGIN   = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     in_data,
   input  logic                                in_last,
   input  logic                                axis_clear,
   input  logic                                M_AXIS_TREADY,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic                                M_AXIS_TLAST,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                fifo_full,
   output logic                                fifo_empty,
   output logic                                almost_full,
   output logic                                overflow,
   output logic                                frame_done,
   output logic [15:0]                         beat_cnt
);

   localparam int DW = C_M_AXIS_TDATA_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] L_DEPTH  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] L_MARGIN = (AW+1)'(ALMOST_FULL_MARGIN);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   logic [DW:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_tvalid;
   logic [DW-1:0] r_tdata;
   logic          r_tlast;
   logic          r_overflow;
   logic [15:0]   r_beat_cnt;
   state_t        r_state;

   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_head_ok;
   logic [AW-1:0] w_rd_next;

   assign w_pop     = r_tvalid & M_AXIS_TREADY & ~axis_clear;
   assign w_push    = in_valid & ~axis_clear & ((r_count < L_DEPTH) | w_pop);
   assign w_drop    = in_valid & ~axis_clear & ~w_push;
   assign w_rd_next = r_rd_ptr + AW'(w_pop);
   // Head after this edge's pop must already be in storage; a beat written on this
   // same edge only becomes visible one edge later.
   assign w_head_ok = r_count > (AW+1)'(w_pop);

   // Storage is not reset: entries are only read once the count says they were written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_last, in_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
         r_tlast    <= 1'b0;
         r_overflow <= 1'b0;
         r_beat_cnt <= '0;
         r_state    <= S_IDLE;
      end else if (axis_clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
         r_tlast    <= 1'b0;
         r_overflow <= 1'b0;
         r_beat_cnt <= '0;
         r_state    <= S_IDLE;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_rd_ptr <= w_rd_next;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_drop) begin
            r_overflow <= 1'b1;
         end

         if (w_head_ok) begin
            r_tvalid           <= 1'b1;
            {r_tlast, r_tdata} <= r_mem[w_rd_next];
         end else begin
            r_tvalid <= 1'b0;
         end

         if (w_pop) begin
            r_beat_cnt <= r_tlast ? 16'd0 : r_beat_cnt + 16'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_pop) r_state <= r_tlast ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
               if (w_pop && r_tlast) r_state <= S_DONE;
            end
            S_DONE: begin
               if (w_pop) r_state <= r_tlast ? S_DONE : S_STREAM;
               else       r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign M_AXIS_TVALID = r_tvalid;
   assign M_AXIS_TDATA  = r_tdata;
   assign M_AXIS_TLAST  = r_tlast;
   assign M_AXIS_TSTRB  = '1;
   assign fifo_empty    = (r_count == '0);
   assign fifo_full     = (r_count == L_DEPTH);
   assign almost_full   = ((L_DEPTH - r_count) <= L_MARGIN);
   assign overflow      = r_overflow;
   assign frame_done    = (r_state == S_DONE);
   assign beat_cnt      = r_beat_cnt;

endmodule

// File: doc/ofmaps_axis_out_fifo.md
OFMAPS_AXIS_OUT_FIFO -- requirements
Module: ofmaps_axis_out_fifo

Interface
REQ-001 Parameter: C_M_AXIS_TDATA_WIDTH, 32, output stream data width in bits.
REQ-002 Parameter: FIFO_DEPTH, 16, number of entries; SHALL be a power of two, 4 or more.
REQ-003 Parameter: ALMOST_FULL_MARGIN, 4, number of free entries at or below which almost_full asserts.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port: in_valid  in  1  producer beat strobe (psum/pool packager output); no ready path back to the producer.
REQ-007 Port: in_data  in  C_M_AXIS_TDATA_WIDTH  producer beat data.
REQ-008 Port: in_last  in  1  marks the final beat of a layer frame.
REQ-009 Port: axis_clear  in  1  synchronous flush.
REQ-010 Port: M_AXIS_TREADY  in  1  downstream ready.
REQ-011 Port: M_AXIS_TVALID / M_AXIS_TDATA / M_AXIS_TLAST  out  1 / C_M_AXIS_TDATA_WIDTH / 1  AXI4-Stream master.
REQ-012 Port: M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all ones.
REQ-013 Port: fifo_full, fifo_empty, almost_full  out  1 each  occupancy flags.
REQ-014 Port: overflow  out  1  sticky flag: a beat was dropped.
REQ-015 Port: frame_done  out  1  one-cycle pulse after the TLAST beat is accepted.
REQ-016 Port: beat_cnt  out  16  beats accepted downstream in the current frame.

Function
REQ-017 Storage: circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus count of log2(FIFO_DEPTH)+1 bits; each entry holds {last, data}.
REQ-018 pop = M_AXIS_TVALID && M_AXIS_TREADY; push = in_valid && (count < FIFO_DEPTH || pop).
REQ-019 On push and pop in the same cycle, count SHALL be unchanged, including when count == FIFO_DEPTH.
REQ-020 in_valid while count == FIFO_DEPTH and no pop: beat dropped, pointers unchanged, overflow set to 1 and held until axis_clear or reset.
REQ-021 Output stage: registered, first-word-fall-through; a beat pushed into an empty FIFO at edge N SHALL present TVALID=1 with its data after edge N+1 (1-cycle latency).
REQ-022 While TVALID=1 and TREADY=0, TDATA and TLAST SHALL hold stable; TVALID SHALL NOT deassert without a pop.
REQ-023 Back-to-back: with TREADY held at 1 and in_valid held at 1, throughput SHALL be one beat per cycle with no bubbles.
REQ-024 Flags are combinational from count: fifo_empty = (count==0); fifo_full = (count==FIFO_DEPTH); almost_full = (FIFO_DEPTH-count <= ALMOST_FULL_MARGIN).
REQ-025 Frame FSM states: IDLE, STREAM, DONE.
  - IDLE->STREAM on first pop.
  - STREAM->DONE on a pop with TLAST=1.
  - DONE->IDLE unconditionally after one cycle, or DONE->STREAM if a pop occurs in that cycle.
  - A single-beat frame (IDLE pop with TLAST=1) SHALL go directly to DONE.
REQ-026 frame_done = 1 exactly in the DONE state.
REQ-027 beat_cnt increments by 1 per pop and wraps at 16 bits; a pop with TLAST=1 loads 0.
REQ-028 axis_clear has priority over push and pop in the same cycle. Next cycle: pointers, count, overflow, beat_cnt = 0; TVALID = 0; FSM in IDLE; a beat offered with axis_clear is discarded.

Reset
REQ-029 While rst_n=0, and after release:
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0.
  - fifo_empty=1, fifo_full=0, almost_full=0.
  - overflow=0, frame_done=0, beat_cnt=0, FSM in IDLE, pointers=0.
REQ-030 Reset asserted mid-frame SHALL discard all stored beats with no further TVALID until a new push.

Verification
REQ-031 Latency: TREADY=1; push 0xA5A5A5A5 with in_last=1 -> TVALID=1 and TLAST=1 next cycle; frame_done pulses one cycle after the pop; beat_cnt returns to 0.
REQ-032 Backpressure: TREADY=0; push 16 beats 0..15 -> fifo_full=1, almost_full has been 1 since count 12, TDATA held at 0. Then TREADY=1 -> beats 0..15 in order, no gaps.
REQ-033 Overflow: full FIFO, TREADY=0, push 0x99 -> overflow=1, count stays 16, 0x99 never emitted; overflow stays 1 until axis_clear.
REQ-034 Full simultaneous push and pop: count=16, TREADY=1, in_valid=1 -> count stays 16, no overflow, new beat emitted after the 15 older beats.
REQ-035 Clear: 5 beats queued plus axis_clear together with in_valid -> next cycle TVALID=0, fifo_empty=1, beat_cnt=0; later pushes stream normally.
REQ-036 Reset mid-frame: 3 beats queued, pulse rst_n low -> all outputs at their REQ-029 values; first post-reset push is emitted with beat_cnt counting from 0.
